conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Parametrised sequencer for the convolution engine: one-hot FSM (IDLE, SET, READ, MULT, ROUND, ADD, WRITE, END) driving the datapath through one-hot command flags.
- Generates its own tap, pixel and channel counters and per-phase done conditions; the datapath supplies no done strobes.
- Adds a memory request/grant handshake with stall support and multi-channel (N_CH) sweeps over an IMG_W x IMG_H image.
- Sits between the top-level start/done interface and the MAC/round/add datapath plus the image/result memories.

Parameters:
IMG_W, 64, image width in pixels (>=2)
IMG_H, 64, image height in pixels (>=1)
KTAPS, 9, kernel taps per output pixel (>=2)
N_CH, 2, kernel channels swept in sequence (>=1)
Local: XW=clog2(IMG_W), YW=clog2(IMG_H), TW=clog2(KTAPS), CW=max(1,clog2(N_CH))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  start request, sampled in IDLE and END only
mem_gnt  in  1  memory accepts the current read/write this cycle
cmd_flags  out  6  one-hot command {WRITE,ADD,ROUND,MULT,READ,SET}, bit0=SET
mem_req  out  1  memory access request (READ, WRITE states)
tap_idx  out  TW  current kernel tap
pix_x  out  XW  current output pixel column
pix_y  out  YW  current output pixel row
ch_idx  out  CW  current kernel channel
busy  out  1  high in SET..WRITE
done  out  1  high in END

Behaviour:
- Reset (reset=0, async): state=IDLE; every output and counter is 0.
- All outputs are decoded combinationally from the registered state and counters. cmd_flags is all-zero in IDLE/END and exactly one bit otherwise.
- IDLE: start=1 -> SET; clear pix_x, pix_y, ch_idx, tap_idx.
- SET: one cycle, tap_idx=0 -> READ.
- READ: mem_req=1.
  - mem_gnt=0: hold state and tap_idx (stall).
  - mem_gnt=1 and tap_idx<KTAPS-1: tap_idx+1.
  - mem_gnt=1 and tap_idx==KTAPS-1: tap_idx=0 -> MULT.
- MULT: exactly KTAPS cycles. tap_idx steps 0..KTAPS-1, one MAC per tap; on tap_idx==KTAPS-1 -> ROUND with tap_idx=0. No stall.
- ROUND: one cycle -> ADD. ADD: one cycle -> WRITE.
- WRITE: mem_req=1; mem_gnt=0 holds. On mem_gnt=1:
  - last pixel (x=IMG_W-1, y=IMG_H-1) and last channel (ch=N_CH-1) -> END.
  - last pixel, other channel: ch_idx+1, x=y=0 -> SET.
  - x==IMG_W-1: x=0, y+1 -> SET.
  - otherwise: x+1 -> SET.
- END: done=1, busy=0, counters hold their final values. start=1 -> SET with all counters cleared (restart). Otherwise stay in END.
- start is ignored in SET..WRITE.
- Zero-stall latency: 2*KTAPS+4 cycles per output pixel (22 for KTAPS=9). Run length = IMG_W*IMG_H*N_CH*(2*KTAPS+4) cycles from the SET entry to END.
- Counters saturate structurally: they never exceed their maxima; wrap logic is applied only at WRITE grant.
- An illegal one-hot state (none or multiple bits set) recovers to IDLE on the next clock.
- Reset asserted mid-run: immediate return to IDLE, mem_req drops asynchronously. The partial pixel is discarded.

Decomposition:
- Shared package/define file (conv_pkg): state bit indices S_IDLE..S_END, STATE_W=8, the zero vector; CMD bit indices CMD_SET..CMD_WRITE, CMD_FLAG_W=6. The datapath and this block both use it.
- One natural sub-module, conv_idx_cnt: the pixel/channel counter (x, y, ch with wrap and last-flags, advance and clear inputs). The FSM and tap counter stay in conv_seq_ctrl.

Test Plan:
- Reset: hold reset=0 with start=1 and mem_gnt=1 -> all outputs 0, state IDLE. Release reset -> SET on the next edge with cmd_flags=6'b000001.
- Zero-stall single pixel (IMG_W=2, IMG_H=1, N_CH=1, KTAPS=9, mem_gnt=1):
  - READ lasts 9 cycles, MULT 9, then ROUND/ADD/WRITE one cycle each.
  - done rises 44 cycles after SET entry.
- Stall: drop mem_gnt for 3 cycles at tap_idx=4 in READ, and 2 cycles in WRITE -> tap_idx holds at 4, pixel total 27 cycles, mem_req stays high throughout.
- Full sweep (IMG_W=4, IMG_H=2, N_CH=2):
  - WRITE grants visit (x,y,ch) in the order (0,0,0),(1,0,0)..(3,1,0),(0,0,1)..(3,1,1): 16 writes.
  - done after 352 cycles.
- Restart and ignored start: pulse start mid-MULT -> no effect. In END, start=1 -> SET with x=y=ch=0 and a second identical run.
- Async reset mid-WRITE with mem_gnt=0: assert reset between clock edges -> mem_req and cmd_flags drop to 0 before the next edge, state IDLE.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine: one-hot state bit
// positions, command flag bit positions and index-width helpers.
package conv_pkg;

    // One-hot state bit positions
    localparam int STATE_W = 8;
    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_READ  = 2;
    localparam int S_MULT  = 3;
    localparam int S_ROUND = 4;
    localparam int S_ADD   = 5;
    localparam int S_WRITE = 6;
    localparam int S_END   = 7;

    localparam logic [STATE_W-1:0] STATE_ZERO = '0;

    // Command flag bit positions (bit0 = SET)
    localparam int CMD_FLAG_W = 6;
    localparam int CMD_SET    = 0;
    localparam int CMD_READ   = 1;
    localparam int CMD_MULT   = 2;
    localparam int CMD_ROUND  = 3;
    localparam int CMD_ADD    = 4;
    localparam int CMD_WRITE  = 5;

    // Command bits map onto the consecutive busy states SET..WRITE
    localparam int CMD_STATE_OFS = S_SET - CMD_SET;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = STATE_W'(1 << S_IDLE),
        ST_SET   = STATE_W'(1 << S_SET),
        ST_READ  = STATE_W'(1 << S_READ),
        ST_MULT  = STATE_W'(1 << S_MULT),
        ST_ROUND = STATE_W'(1 << S_ROUND),
        ST_ADD   = STATE_W'(1 << S_ADD),
        ST_WRITE = STATE_W'(1 << S_WRITE),
        ST_END   = STATE_W'(1 << S_END)
    } state_t;

    // Index width for a counter running 0..n-1; never narrower than one bit
    // so that degenerate dimensions (n == 1) still yield a legal port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot vector with only bit 'pos' set
    function automatic logic [STATE_W-1:0] state_bit(input int pos);
        logic [STATE_W-1:0] v;
        v      = STATE_ZERO;
        v[pos] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/conv_idx_cnt.sv
// Pixel/channel position counter for the convolution sequencer.
// Walks x fastest, then y, then channel. Each field only increments while
// below its maximum, so no field can ever exceed its range.
module conv_idx_cnt
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int N_CH  = 2,
    localparam int XW = idx_width(IMG_W),
    localparam int YW = idx_width(IMG_H),
    localparam int CW = idx_width(N_CH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] ch,
    output logic          last_pix,
    output logic          last_all
);

    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
    localparam logic [CW-1:0] CH_MAX = CW'(N_CH - 1);

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [CW-1:0] ch_reg;
    logic          last_x;
    logic          last_y;
    logic          last_ch;

    assign last_x   = (x_reg == X_MAX);
    assign last_y   = (y_reg == Y_MAX);
    assign last_ch  = (ch_reg == CH_MAX);
    assign last_pix = last_x & last_y;
    assign last_all = last_pix & last_ch;

    // Position update: clear wins, otherwise step x, wrapping into y then ch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg  <= '0;
            y_reg  <= '0;
            ch_reg <= '0;
        end else if (clear) begin
            x_reg  <= '0;
            y_reg  <= '0;
            ch_reg <= '0;
        end else if (advance) begin
            if (!last_x) begin
                x_reg <= x_reg + XW'(1);
            end else begin
                x_reg <= '0;
                if (!last_y) begin
                    y_reg <= y_reg + YW'(1);
                end else begin
                    y_reg <= '0;
                    // Final channel holds; the FSM never advances past it
                    if (!last_ch) begin
                        ch_reg <= ch_reg + CW'(1);
                    end
                end
            end
        end
    end

    assign x  = x_reg;
    assign y  = y_reg;
    assign ch = ch_reg;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer. A one-hot FSM walks every output pixel of every
// kernel channel through SET -> READ (KTAPS granted reads) -> MULT (KTAPS
// MACs) -> ROUND -> ADD -> WRITE (one granted write). The tap counter lives
// here; the pixel/channel position lives in conv_idx_cnt. All outputs are
// decoded from registered state so they follow the asynchronous reset.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int KTAPS = 9,
    parameter int N_CH  = 2,
    localparam int XW = idx_width(IMG_W),
    localparam int YW = idx_width(IMG_H),
    localparam int TW = idx_width(KTAPS),
    localparam int CW = idx_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mem_gnt,
    output logic [CMD_FLAG_W-1:0] cmd_flags,
    output logic                  mem_req,
    output logic [TW-1:0]         tap_idx,
    output logic [XW-1:0]         pix_x,
    output logic [YW-1:0]         pix_y,
    output logic [CW-1:0]         ch_idx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [TW-1:0] TAP_MAX = TW'(KTAPS - 1);

    state_t               state_reg;
    logic [STATE_W-1:0]   state_vec;
    logic [TW-1:0]        tap_reg;
    logic                 tap_last;
    logic                 in_idle;
    logic                 in_write;
    logic                 in_end;
    logic                 pos_clear;
    logic                 pos_advance;
    logic                 last_pix;
    logic                 last_all;

    assign state_vec = state_reg;
    assign tap_last  = (tap_reg == TAP_MAX);

    // Full-vector compares so a corrupted (non one-hot) state decodes to
    // nothing at all rather than to several commands at once.
    assign in_idle  = (state_vec == state_bit(S_IDLE));
    assign in_write = (state_vec == state_bit(S_WRITE));
    assign in_end   = (state_vec == state_bit(S_END));

    // A new run restarts the sweep from pixel (0,0), channel 0
    assign pos_clear   = (in_idle | in_end) & start;
    // The final write leaves the position at its last value for inspection
    assign pos_advance = in_write & mem_gnt & ~last_all;

    conv_idx_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .N_CH  (N_CH)
    ) u_idx_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (pos_clear),
        .advance  (pos_advance),
        .x        (pix_x),
        .y        (pix_y),
        .ch       (ch_idx),
        .last_pix (last_pix),
        .last_all (last_all)
    );

    // Sequencer FSM and tap counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            tap_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_SET;
                        tap_reg   <= '0;
                    end
                end
                ST_SET: begin
                    tap_reg   <= '0;
                    state_reg <= ST_READ;
                end
                ST_READ: begin
                    // Without a grant the read is retried with the same tap
                    if (mem_gnt) begin
                        if (tap_last) begin
                            tap_reg   <= '0;
                            state_reg <= ST_MULT;
                        end else begin
                            tap_reg <= tap_reg + TW'(1);
                        end
                    end
                end
                ST_MULT: begin
                    if (tap_last) begin
                        tap_reg   <= '0;
                        state_reg <= ST_ROUND;
                    end else begin
                        tap_reg <= tap_reg + TW'(1);
                    end
                end
                ST_ROUND: begin
                    state_reg <= ST_ADD;
                end
                ST_ADD: begin
                    state_reg <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (mem_gnt) begin
                        state_reg <= last_all ? ST_END : ST_SET;
                    end
                end
                ST_END: begin
                    if (start) begin
                        state_reg <= ST_SET;
                        tap_reg   <= '0;
                    end
                end
                default: begin
                    // Corrupted state vector: fall back to a clean idle
                    state_reg <= ST_IDLE;
                    tap_reg   <= '0;
                end
            endcase
        end
    end

    // Command decode: each flag is high only in its own busy state
    for (genvar gi = 0; gi < CMD_FLAG_W; gi++) begin : g_cmd
        assign cmd_flags[gi] = (state_vec == state_bit(gi + CMD_STATE_OFS));
    end

    assign mem_req = cmd_flags[CMD_READ] | cmd_flags[CMD_WRITE];
    assign busy    = |cmd_flags;
    assign done    = in_end;
    assign tap_idx = tap_reg;

    // last_pix is exposed by the counter for datapath use; not needed here
    logic unused_last_pix;
    assign unused_last_pix = last_pix;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl: scoreboard of expected write positions and
// per-pixel / per-run cycle budgets, with directed and random grant stalls.
module tb_conv_seq_ctrl;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int NCH = 2;
    localparam int K   = 9;
    localparam int PIX_CYC = 2 * K + 4;

    localparam int C_SET   = 0;
    localparam int C_READ  = 1;
    localparam int C_MULT  = 2;
    localparam int C_ROUND = 3;
    localparam int C_ADD   = 4;
    localparam int C_WRITE = 5;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mem_gnt;
    logic [5:0] cmd_flags;
    logic       mem_req;
    logic [3:0] tap_idx;
    logic [1:0] pix_x;
    logic [0:0] pix_y;
    logic [0:0] ch_idx;
    logic       busy;
    logic       done;

    conv_seq_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .KTAPS (K),
        .N_CH  (NCH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_gnt   (mem_gnt),
        .cmd_flags (cmd_flags),
        .mem_req   (mem_req),
        .tap_idx   (tap_idx),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .ch_idx    (ch_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int x;
        int y;
        int ch;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   gnt_mode = 0;   // 0: always grant, 1: random, 2: directed stall, 3: never
    int   wr_count = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a run writes every pixel, x fastest, then y, then channel
    task automatic issue_run();
        pix_t p;
        for (int c = 0; c < NCH; c++)
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++) begin
                    p.x = xx; p.y = yy; p.ch = c;
                    exp_q.push_back(p);
                end
    endtask

    // Grant driver: changes mem_gnt shortly after each rising edge
    int rd_stall = 0;
    int wr_stall = 0;
    initial begin
        mem_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (gnt_mode != 2) begin
                rd_stall = 0;
                wr_stall = 0;
            end
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: mem_gnt = ($urandom_range(0, 3) != 0);
                2: begin
                    if (cmd_flags[C_READ] && tap_idx == 4'd4 && rd_stall < 3) begin
                        mem_gnt = 1'b0;
                        rd_stall++;
                    end else if (cmd_flags[C_WRITE] && wr_stall < 2) begin
                        mem_gnt = 1'b0;
                        wr_stall++;
                    end else begin
                        mem_gnt = 1'b1;
                    end
                end
                default: mem_gnt = 1'b0;
            endcase
        end
    end

    // Monitor: per-cycle decode rules, write scoreboard, pixel and run lengths
    int pix_cyc = 0, pix_deny = 0, run_cyc = 0, run_deny = 0;
    bit done_seen = 0;
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                pix_cyc = 0; pix_deny = 0; run_cyc = 0; run_deny = 0;
                done_seen = 0;
            end else begin
                if (busy) begin pix_cyc++; run_cyc++; end
                if (mem_req && !mem_gnt) begin pix_deny++; run_deny++; end
                checks++;
                if (mem_req !== (cmd_flags[C_READ] | cmd_flags[C_WRITE]) ||
                    busy !== (cmd_flags != 6'd0) ||
                    (cmd_flags != 6'd0 && !$onehot(cmd_flags)) ||
                    (busy && done)) begin
                    errors++;
                    $display("FAIL decode: cmd_flags=%b mem_req=%b busy=%b done=%b",
                             cmd_flags, mem_req, busy, done);
                end
                if (cmd_flags[C_WRITE] && mem_gnt) begin
                    wr_count++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL write_unexpected: got x=%0d y=%0d ch=%0d, none required",
                                 pix_x, pix_y, ch_idx);
                    end else begin
                        e = exp_q.pop_front();
                        $display("write x=%0d y=%0d ch=%0d cycles=%0d (stalls %0d)",
                                 pix_x, pix_y, ch_idx, pix_cyc, pix_deny);
                        chk("write_x", pix_x, e.x);
                        chk("write_y", pix_y, e.y);
                        chk("write_ch", ch_idx, e.ch);
                        chk("pixel_cycles", pix_cyc, PIX_CYC + pix_deny);
                    end
                    pix_cyc = 0;
                    pix_deny = 0;
                end
                if (done && !done_seen) begin
                    done_seen = 1;
                    chk("run_cycles", run_cyc, W * H * NCH * PIX_CYC + run_deny);
                    chk("writes_left_at_done", exp_q.size(), 0);
                    run_cyc = 0;
                    run_deny = 0;
                end
                if (busy) done_seen = 0;
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    int pix_len;
    int guard;
    initial begin
        reset = 1'b0;
        start = 1'b1;
        gnt_mode = 0;

        // Reset held with start and grant high: everything idle and zero
        repeat (3) @(negedge clk);
        chk("rst_cmd_flags", cmd_flags, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tap", tap_idx, 0);
        chk("rst_pos", {pix_x, pix_y, ch_idx}, 0);

        // Run 1: directed stalls in the first pixel, start pulse mid-MULT
        gnt_mode = 2;
        issue_run();
        reset = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("set_after_reset", cmd_flags, 6'b000001);
        chk("set_tap", tap_idx, 0);
        pix_len = 1;
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            pix_len++;
            guard++;
            if (cmd_flags[C_READ] && !mem_gnt) chk("read_stall_tap", tap_idx, 4);
            if (cmd_flags[C_WRITE] && !mem_gnt) chk("write_stall_req", mem_req, 1);
            if (cmd_flags[C_WRITE] && mem_gnt) break;
        end
        chk("stalled_pixel_len", pix_len, PIX_CYC + 5);

        guard = 0;
        while (!(cmd_flags[C_MULT] && tap_idx == 4'd3) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("mult_start_ignored_flags", cmd_flags, 6'b000100);
        chk("mult_start_ignored_tap", tap_idx, 4);

        wait_done("run1");
        chk("end_x", pix_x, W - 1);
        chk("end_y", pix_y, H - 1);
        chk("end_ch", ch_idx, NCH - 1);
        chk("end_cmd", cmd_flags, 0);
        repeat (3) @(negedge clk);
        chk("end_hold_done", done, 1);
        chk("end_hold_pos", {pix_x, pix_y, ch_idx}, {2'(W - 1), 1'(H - 1), 1'(NCH - 1)});

        // Run 2: restart from END with random grant stalls
        gnt_mode = 1;
        issue_run();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("restart_set", cmd_flags, 6'b000001);
        chk("restart_pos", {pix_x, pix_y, ch_idx}, 0);
        wait_done("run2");

        // Run 3: abort with reset in a WRITE that is being refused
        gnt_mode = 0;
        issue_run();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (!(cmd_flags[C_ADD] && wr_count >= 37) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        gnt_mode = 3;
        @(negedge clk);
        chk("abort_pre_write", cmd_flags, 6'b100000);
        chk("abort_pre_req", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_req_async", mem_req, 0);
        chk("abort_cmd_async", cmd_flags, 0);
        chk("abort_busy_async", busy, 0);
        chk("abort_pos_async", {pix_x, pix_y, ch_idx}, 0);
        repeat (2) @(negedge clk);
        gnt_mode = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_abort_cmd", cmd_flags, 0);
        chk("idle_after_abort_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
